// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID-stage opcode decoder plus the ID/EX, EX/MEM and MEM/WB control
// registers of a 5-stage MIPS pipeline, with load-use / branch-in-ID hazard
// detection driving stall, bubble and flush controls.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   hold_i                global freeze; all pipeline state holds
//   valid_i, op_i         ID instruction valid and opcode
//   rs_i, rt_i, rd_i      ID register fields
//   eq_i                  ID comparator result (rs == rt)
//   stall_o, flush_o      hold PC/IF-ID, clear IF-ID (combinational)
//   jump_o, branch_o      next-PC target selects (combinational)
//   illegal_o             valid unknown opcode in ID (combinational)
//   ex_*, mem_*, wb_*     registered control fields of each later stage
module ctrl_pipe #(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned ALUOP_W = 2,
    parameter bit          EN_BNE  = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hold_i,
    input  logic               valid_i,
    input  logic [5:0]         op_i,
    input  logic [REG_W-1:0]   rs_i,
    input  logic [REG_W-1:0]   rt_i,
    input  logic [REG_W-1:0]   rd_i,
    input  logic               eq_i,
    output logic               stall_o,
    output logic               flush_o,
    output logic               jump_o,
    output logic               branch_o,
    output logic               illegal_o,
    output logic               ex_alusrc_o,
    output logic [ALUOP_W-1:0] ex_aluop_o,
    output logic [REG_W-1:0]   ex_dst_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [REG_W-1:0]   mem_dst_o,
    output logic               wb_regwrite_o,
    output logic               wb_memtoreg_o,
    output logic [REG_W-1:0]   wb_dst_o
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Decoded ID fields
    logic               w_known;
    logic               w_alusrc;
    logic [ALUOP_W-1:0] w_aluop;
    logic               w_regdst;
    logic               w_memread;
    logic               w_memwrite;
    logic               w_regwrite;
    logic               w_memtoreg;
    logic               w_is_beq;
    logic               w_is_bne;
    logic               w_is_j;
    logic               w_reads_rt;
    logic               w_reads_rs;
    logic [REG_W-1:0]   w_dst;
    logic               w_regwrite_eff;

    // Hazard and bubble terms
    logic w_load_use;
    logic w_branch_hz;
    logic w_hazard;
    logic w_bubble;

    // Stage registers
    logic               r_ex_alusrc;
    logic [ALUOP_W-1:0] r_ex_aluop;
    logic [REG_W-1:0]   r_ex_dst;
    logic               r_ex_memread;
    logic               r_ex_memwrite;
    logic               r_ex_regwrite;
    logic               r_ex_memtoreg;
    logic               r_mem_memread;
    logic               r_mem_memwrite;
    logic               r_mem_regwrite;
    logic               r_mem_memtoreg;
    logic [REG_W-1:0]   r_mem_dst;
    logic               r_wb_regwrite;
    logic               r_wb_memtoreg;
    logic [REG_W-1:0]   r_wb_dst;

    // Opcode decode
    always_comb begin
        w_known    = 1'b1;
        w_alusrc   = 1'b0;
        w_aluop    = '0;
        w_regdst   = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_is_beq   = 1'b0;
        w_is_bne   = 1'b0;
        w_is_j     = 1'b0;
        w_reads_rt = 1'b0;
        case (op_i)
            OP_R: begin
                w_aluop    = ALUOP_W'(2'd2);
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_reads_rt = 1'b1;
            end
            OP_ADDI: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_LW: begin
                w_alusrc   = 1'b1;
                w_memread  = 1'b1;
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            OP_SW: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
                w_reads_rt = 1'b1;
            end
            OP_BEQ: begin
                w_aluop    = ALUOP_W'(2'd1);
                w_is_beq   = 1'b1;
                w_reads_rt = 1'b1;
            end
            OP_BNE: begin
                if (EN_BNE) begin
                    w_aluop    = ALUOP_W'(2'd1);
                    w_is_bne   = 1'b1;
                    w_reads_rt = 1'b1;
                end else begin
                    w_known = 1'b0;
                end
            end
            OP_J: begin
                w_is_j = 1'b1;
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

    assign w_reads_rs     = ~w_is_j;
    assign w_dst          = w_regdst ? rd_i : rt_i;
    // Writes to $0 are dropped at decode so later stages never forward them
    assign w_regwrite_eff = w_regwrite & (w_dst != '0);

    // Load in EX whose destination an ID operand needs
    assign w_load_use = r_ex_memread && (r_ex_dst != '0) &&
                        ((w_reads_rs && (r_ex_dst == rs_i)) ||
                         (w_reads_rt && (r_ex_dst == rt_i)));

    // Branch compares in ID, so it waits on any EX result and on a load in MEM
    assign w_branch_hz = (w_is_beq | w_is_bne) &&
                         ((r_ex_regwrite && (r_ex_dst != '0) &&
                           ((r_ex_dst == rs_i) || (r_ex_dst == rt_i))) ||
                          (r_mem_memread && (r_mem_dst != '0) &&
                           ((r_mem_dst == rs_i) || (r_mem_dst == rt_i))));

    assign w_hazard  = valid_i & (w_load_use | w_branch_hz);
    assign w_bubble  = ~valid_i | w_hazard | ~w_known;

    assign stall_o   = w_hazard & ~hold_i;
    assign branch_o  = valid_i & ~w_hazard & ~hold_i &
                       ((w_is_beq & eq_i) | (w_is_bne & ~eq_i));
    assign jump_o    = valid_i & ~hold_i & w_is_j;
    assign flush_o   = branch_o | jump_o;
    assign illegal_o = valid_i & ~w_known;

    // Control pipeline: reset > hold > advance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex_alusrc    <= 1'b0;
            r_ex_aluop     <= '0;
            r_ex_dst       <= '0;
            r_ex_memread   <= 1'b0;
            r_ex_memwrite  <= 1'b0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memtoreg  <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_dst      <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_dst       <= '0;
        end else if (!hold_i) begin
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_dst       <= r_mem_dst;
            r_mem_memread  <= r_ex_memread;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memtoreg <= r_ex_memtoreg;
            r_mem_dst      <= r_ex_dst;
            if (w_bubble) begin
                r_ex_alusrc   <= 1'b0;
                r_ex_aluop    <= '0;
                r_ex_dst      <= '0;
                r_ex_memread  <= 1'b0;
                r_ex_memwrite <= 1'b0;
                r_ex_regwrite <= 1'b0;
                r_ex_memtoreg <= 1'b0;
            end else begin
                r_ex_alusrc   <= w_alusrc;
                r_ex_aluop    <= w_aluop;
                r_ex_dst      <= w_dst;
                r_ex_memread  <= w_memread;
                r_ex_memwrite <= w_memwrite;
                r_ex_regwrite <= w_regwrite_eff;
                r_ex_memtoreg <= w_memtoreg;
            end
        end
    end

    assign ex_alusrc_o   = r_ex_alusrc;
    assign ex_aluop_o    = r_ex_aluop;
    assign ex_dst_o      = r_ex_dst;
    assign mem_read_o    = r_mem_memread;
    assign mem_write_o   = r_mem_memwrite;
    assign mem_dst_o     = r_mem_dst;
    assign wb_regwrite_o = r_wb_regwrite;
    assign wb_memtoreg_o = r_wb_memtoreg;
    assign wb_dst_o      = r_wb_dst;

endmodule
